// File: rtl/id_pipe_control_pkg.sv
// Shared opcode patterns, ALUOp encodings and control bundle type for the
// LEGv8 pipelined ID-stage control.
package id_pipe_control_pkg;

    localparam logic [1:0] ALUOp_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOp_DTYPE  = 2'b00;
    localparam logic [1:0] ALUOp_BRANCH = 2'b01;

    // Each opcode is a pattern plus a care-mask; zero mask bits are don't-cares.
    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_ADDI   = 11'b10010001000;
    localparam logic [10:0] OP_SUBI   = 11'b11010001000;
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_CBZ    = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ   = 11'b10110101000;
    localparam logic [10:0] OP_B      = 11'b00010100000;

    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_IMM  = 11'b11111111110;
    localparam logic [10:0] MASK_CB   = 11'b11111111000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    typedef struct packed {
        logic       reg2_loc;
        logic       uncondbranch;
        logic       branch;
        logic       branch_nz;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef enum logic {
        R2_RM = 1'b0,
        R2_RD = 1'b1
    } r2_sel_e;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] pat,
                                      input logic [10:0] mask);
        return ((op ^ pat) & mask) == 11'b0;
    endfunction

endpackage

// File: rtl/id_pipe_control_decode.sv
// Purely combinational opcode decode: control bundle, illegal flag and which
// register sources the instruction reads.
module control_decode
    import id_pipe_control_pkg::*;
#(
    parameter bit EN_IMM  = 1'b1,
    parameter bit EN_CBNZ = 1'b1
) (
    input  logic [10:0] opcode_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o,
    output logic        uses_rn_o,
    output logic        uses_r2_o,
    output r2_sel_e     r2_sel_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        uses_rn_o = 1'b0;
        uses_r2_o = 1'b0;
        r2_sel_o  = R2_RM;

        if (op_match(opcode_i, OP_ADD, MASK_FULL) || op_match(opcode_i, OP_SUB, MASK_FULL) ||
            op_match(opcode_i, OP_AND, MASK_FULL) || op_match(opcode_i, OP_ORR, MASK_FULL)) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALUOp_RTYPE;
            uses_rn_o        = 1'b1;
            uses_r2_o        = 1'b1;
        end else if (EN_IMM && (op_match(opcode_i, OP_ADDI, MASK_IMM) ||
                                op_match(opcode_i, OP_SUBI, MASK_IMM))) begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALUOp_RTYPE;
            uses_rn_o        = 1'b1;
        end else if (op_match(opcode_i, OP_LDUR, MASK_FULL)) begin
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.alu_op     = ALUOp_DTYPE;
            uses_rn_o         = 1'b1;
        end else if (op_match(opcode_i, OP_STUR, MASK_FULL)) begin
            ctrl_o.reg2_loc  = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = ALUOp_DTYPE;
            uses_rn_o        = 1'b1;
            uses_r2_o        = 1'b1;
            r2_sel_o         = R2_RD;
        end else if (op_match(opcode_i, OP_CBZ, MASK_CB)) begin
            ctrl_o.reg2_loc = 1'b1;
            ctrl_o.branch   = 1'b1;
            ctrl_o.alu_op   = ALUOp_BRANCH;
            uses_r2_o       = 1'b1;
            r2_sel_o        = R2_RD;
        end else if (EN_CBNZ && op_match(opcode_i, OP_CBNZ, MASK_CB)) begin
            ctrl_o.reg2_loc  = 1'b1;
            ctrl_o.branch    = 1'b1;
            ctrl_o.branch_nz = 1'b1;
            ctrl_o.alu_op    = ALUOp_BRANCH;
            uses_r2_o        = 1'b1;
            r2_sel_o         = R2_RD;
        end else if (op_match(opcode_i, OP_B, MASK_B)) begin
            ctrl_o.uncondbranch = 1'b1;
            ctrl_o.alu_op       = ALUOp_BRANCH;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/id_pipe_control.sv
// ID-stage control for the LEGv8 pipeline: decode into ID/EX, load-use stall
// with bubble insertion, branch flush, illegal-opcode flag and stall counter.
module id_pipe_control
    import id_pipe_control_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter bit EN_IMM  = 1'b1,
    parameter bit EN_CBNZ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [10:0]       id_opcode,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_flush,
    output logic              if_stall,
    output logic              id_flush,
    output logic              ex_valid,
    output logic              ex_reg2_loc,
    output logic              ex_uncondbranch,
    output logic              ex_branch,
    output logic              ex_branch_nz,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [1:0]        ex_alu_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic              illegal_sticky,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [REG_AW-1:0] ZERO_REG = '1;

    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic              dec_uses_rn;
    logic              dec_uses_r2;
    r2_sel_e           dec_r2_sel;
    logic [REG_AW-1:0] id_r2;
    logic              hazard;

    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    control_decode #(
        .EN_IMM  (EN_IMM),
        .EN_CBNZ (EN_CBNZ)
    ) u_decode (
        .opcode_i  (id_opcode),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .uses_rn_o (dec_uses_rn),
        .uses_r2_o (dec_uses_r2),
        .r2_sel_o  (dec_r2_sel)
    );

    assign id_r2 = (dec_r2_sel == R2_RD) ? id_rd : id_rm;

    // A load writing XZR never produces a value, so it cannot cause a stall.
    always_comb begin
        hazard = valid_q && ctrl_q.mem_read && (rd_q != ZERO_REG) && id_valid &&
                 ((dec_uses_rn && (id_rn == rd_q)) || (dec_uses_r2 && (id_r2 == rd_q)));
    end

    assign if_stall = hazard && !ex_flush;
    assign id_flush = ex_flush;

    // Flush, stall, invalid and illegal slots all load a fully zeroed bubble.
    always_comb begin
        valid_d  = 1'b0;
        ctrl_d   = '0;
        rd_d     = '0;
        sticky_d = sticky_q | (id_valid & dec_illegal);
        cnt_d    = cnt_q;

        if (!ex_flush && !hazard && id_valid && !dec_illegal) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            rd_d    = id_rd;
        end

        if (if_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rd_q     <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rd_q     <= rd_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid        = valid_q;
    assign ex_reg2_loc     = ctrl_q.reg2_loc;
    assign ex_uncondbranch = ctrl_q.uncondbranch;
    assign ex_branch       = ctrl_q.branch;
    assign ex_branch_nz    = ctrl_q.branch_nz;
    assign ex_mem_read     = ctrl_q.mem_read;
    assign ex_mem_to_reg   = ctrl_q.mem_to_reg;
    assign ex_mem_write    = ctrl_q.mem_write;
    assign ex_alu_src      = ctrl_q.alu_src;
    assign ex_reg_write    = ctrl_q.reg_write;
    assign ex_alu_op       = ctrl_q.alu_op;
    assign ex_rd           = rd_q;
    assign illegal_sticky  = sticky_q;
    assign stall_count     = cnt_q;

endmodule

// File: tb/tb_id_pipe_control.sv
// Scoreboard bench for id_pipe_control: a default instance and a reduced one
// (no CBNZ, 2-bit stall counter) share one stimulus stream.
module tb_id_pipe_control;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001001;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010110011;
    localparam logic [10:0] OP_ILL  = 11'b11111111111;

    typedef struct packed {
        logic        valid;
        logic [10:0] ctrl;
        logic [4:0]  rd;
        logic        sticky;
        logic [15:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [10:0] id_opcode = '0;
    logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
    logic        ex_flush = 1'b0;

    logic        ifStall0, idFlush0, exValid0, sticky0;
    logic        ifStall1, idFlush1, exValid1, sticky1;
    logic [10:0] obsCtrl0, obsCtrl1;
    logic [4:0]  exRd0, exRd1;
    logic [15:0] count0;
    logic [1:0]  count1;

    int assertCount = 0;
    int failCount   = 0;

    exp_t        expQ0[$], expQ1[$];
    logic        mValid[2];
    logic [10:0] mCtrl[2];
    logic [4:0]  mRd[2];
    logic        mSticky[2];
    int          mCount[2];
    int          mMax[2] = '{65535, 3};

    always #5 clk = ~clk;

    id_pipe_control dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .ex_flush(ex_flush),
        .if_stall(ifStall0), .id_flush(idFlush0), .ex_valid(exValid0),
        .ex_reg2_loc(obsCtrl0[10]), .ex_uncondbranch(obsCtrl0[9]), .ex_branch(obsCtrl0[8]),
        .ex_branch_nz(obsCtrl0[7]), .ex_mem_read(obsCtrl0[6]), .ex_mem_to_reg(obsCtrl0[5]),
        .ex_mem_write(obsCtrl0[4]), .ex_alu_src(obsCtrl0[3]), .ex_reg_write(obsCtrl0[2]),
        .ex_alu_op(obsCtrl0[1:0]), .ex_rd(exRd0), .illegal_sticky(sticky0), .stall_count(count0)
    );

    id_pipe_control #(.REG_AW(5), .CNT_W(2), .EN_IMM(1'b1), .EN_CBNZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .ex_flush(ex_flush),
        .if_stall(ifStall1), .id_flush(idFlush1), .ex_valid(exValid1),
        .ex_reg2_loc(obsCtrl1[10]), .ex_uncondbranch(obsCtrl1[9]), .ex_branch(obsCtrl1[8]),
        .ex_branch_nz(obsCtrl1[7]), .ex_mem_read(obsCtrl1[6]), .ex_mem_to_reg(obsCtrl1[5]),
        .ex_mem_write(obsCtrl1[4]), .ex_alu_src(obsCtrl1[3]), .ex_reg_write(obsCtrl1[2]),
        .ex_alu_op(obsCtrl1[1:0]), .ex_rd(exRd1), .illegal_sticky(sticky1), .stall_count(count1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Returns {illegal, usesRn, usesR2, r2IsRd, ctrl[10:0]}; ctrl is
    // {reg2_loc, uncond, branch, branch_nz, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}.
    function automatic logic [14:0] refDecode(input logic [10:0] op, input bit enCbnz);
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return {4'b0110, 9'b000000001, 2'b10};
            11'b1001000100?, 11'b1101000100?: return {4'b0100, 9'b000000011, 2'b10};
            11'b11111000010:                  return {4'b0100, 9'b000011011, 2'b00};
            11'b11111000000:                  return {4'b0111, 9'b100000110, 2'b00};
            11'b10110100???:                  return {4'b0011, 9'b101000000, 2'b01};
            11'b10110101???: begin
                if (enCbnz) return {4'b0011, 9'b101100000, 2'b01};
                return {4'b1000, 11'b0};
            end
            11'b000101?????:                  return {4'b0000, 9'b010000000, 2'b01};
            default:                          return {4'b1000, 11'b0};
        endcase
    endfunction

    task automatic modelStep(input int k, input logic v, input logic [10:0] op,
                             input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                             input logic fl, output logic stall, output exp_t e);
        logic [14:0] dec;
        logic [4:0]  src2;
        logic        hz;
        dec  = refDecode(op, (k == 0));
        src2 = dec[11] ? rd : rm;
        hz = mValid[k] && mCtrl[k][6] && (mRd[k] != 5'd31) && v &&
             ((dec[13] && (rn == mRd[k])) || (dec[12] && (src2 == mRd[k])));
        stall = hz && !fl;
        if (stall && (mCount[k] < mMax[k])) mCount[k]++;
        mSticky[k] = mSticky[k] | (v & dec[14]);
        if (fl || hz || !v || dec[14]) begin
            mValid[k] = 1'b0; mCtrl[k] = '0; mRd[k] = '0;
        end else begin
            mValid[k] = 1'b1; mCtrl[k] = dec[10:0]; mRd[k] = rd;
        end
        e = '{valid: mValid[k], ctrl: mCtrl[k], rd: mRd[k], sticky: mSticky[k],
              count: 16'(mCount[k])};
    endtask

    task automatic checkEx(input int k);
        exp_t e;
        if ((k == 0 ? expQ0.size() : expQ1.size()) == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
        if (k == 0) begin
            checkOutput("ex_valid0", 32'(exValid0), 32'(e.valid));
            checkOutput("ex_ctrl0",  32'(obsCtrl0), 32'(e.ctrl));
            checkOutput("ex_rd0",    32'(exRd0),    32'(e.rd));
            checkOutput("sticky0",   32'(sticky0),  32'(e.sticky));
            checkOutput("count0",    32'(count0),   32'(e.count));
        end else begin
            checkOutput("ex_valid1", 32'(exValid1), 32'(e.valid));
            checkOutput("ex_ctrl1",  32'(obsCtrl1), 32'(e.ctrl));
            checkOutput("ex_rd1",    32'(exRd1),    32'(e.rd));
            checkOutput("sticky1",   32'(sticky1),  32'(e.sticky));
            checkOutput("count1",    32'(count1),   32'(e.count));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [10:0] op, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [4:0] rd, input logic fl);
        logic s0, s1;
        exp_t e0, e1;
        @(negedge clk);
        id_valid = v; id_opcode = op; id_rn = rn; id_rm = rm; id_rd = rd; ex_flush = fl;
        #1;
        modelStep(0, v, op, rn, rm, rd, fl, s0, e0);
        modelStep(1, v, op, rn, rm, rd, fl, s1, e1);
        checkOutput("if_stall0", 32'(ifStall0), 32'(s0));
        checkOutput("if_stall1", 32'(ifStall1), 32'(s1));
        checkOutput("id_flush0", 32'(idFlush0), 32'(fl));
        checkOutput("id_flush1", 32'(idFlush1), 32'(fl));
        expQ0.push_back(e0);
        expQ1.push_back(e1);
        @(posedge clk);
        #1;
        checkEx(0);
        checkEx(1);
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            mValid[k] = 1'b0; mCtrl[k] = '0; mRd[k] = '0; mSticky[k] = 1'b0; mCount[k] = 0;
        end
        expQ0.delete();
        expQ1.delete();
    endtask

    task automatic checkResetState();
        checkOutput("rst_valid0", 32'(exValid0), 32'd0);
        checkOutput("rst_ctrl0",  32'(obsCtrl0), 32'd0);
        checkOutput("rst_rd0",    32'(exRd0),    32'd0);
        checkOutput("rst_sticky0", 32'(sticky0), 32'd0);
        checkOutput("rst_count0", 32'(count0),   32'd0);
        checkOutput("rst_valid1", 32'(exValid1), 32'd0);
        checkOutput("rst_ctrl1",  32'(obsCtrl1), 32'd0);
        checkOutput("rst_count1", 32'(count1),   32'd0);
        checkOutput("rst_sticky1", 32'(sticky1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;

        // Basic decode of each instruction class.
        applyStimulus(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        applyStimulus(1'b1, OP_SUB, 5'd4, 5'd5, 5'd6, 1'b0);
        applyStimulus(1'b1, OP_ADDI, 5'd7, 5'd0, 5'd8, 1'b0);
        applyStimulus(1'b1, OP_SUBI, 5'd9, 5'd0, 5'd10, 1'b0);
        applyStimulus(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd11, 1'b0);
        applyStimulus(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // LDUR then dependent ADD: one stall, then ADD re-presented.
        applyStimulus(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0);
        applyStimulus(1'b1, OP_ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        applyStimulus(1'b1, OP_ADD, 5'd5, 5'd2, 5'd6, 1'b0);

        // XZR destination never stalls.
        applyStimulus(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd31, 1'b0);
        applyStimulus(1'b1, OP_ADD, 5'd31, 5'd1, 5'd2, 1'b0);

        // STUR reads Rt through the rd field.
        applyStimulus(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd4, 1'b0);
        applyStimulus(1'b1, OP_STUR, 5'd2, 5'd0, 5'd4, 1'b0);
        applyStimulus(1'b1, OP_STUR, 5'd2, 5'd0, 5'd4, 1'b0);

        // B has no sources.
        applyStimulus(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd4, 1'b0);
        applyStimulus(1'b1, OP_B, 5'd4, 5'd4, 5'd4, 1'b0);

        // Flush wins over a simultaneous hazard.
        applyStimulus(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd7, 1'b0);
        applyStimulus(1'b1, OP_ORR, 5'd7, 5'd7, 5'd3, 1'b1);
        applyStimulus(1'b1, OP_ORR, 5'd7, 5'd7, 5'd3, 1'b0);

        // CBNZ: legal on dut0, illegal on dut1.
        applyStimulus(1'b1, OP_CBNZ, 5'd0, 5'd0, 5'd3, 1'b0);

        // Illegal opcode, then ten legal instructions keep the sticky flag.
        applyStimulus(1'b1, OP_ILL, 5'd1, 5'd2, 5'd9, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, OP_ADD, 5'(i), 5'(i + 1), 5'(i + 2), 1'b0);
        end

        // Five more stalls; the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd8, 1'b0);
            applyStimulus(1'b1, OP_ADD, 5'd1, 5'd8, 5'd9, 1'b0);
            applyStimulus(1'b1, OP_ADD, 5'd1, 5'd8, 5'd9, 1'b0);
        end

        // Reset asserted mid-stall clears state immediately.
        applyStimulus(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd10, 1'b0);
        @(negedge clk);
        id_valid = 1'b1; id_opcode = OP_ADD; id_rn = 5'd10; id_rm = 5'd1; id_rd = 5'd12;
        #1;
        checkOutput("pre_reset_stall", 32'(ifStall0), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_stall", 32'(ifStall0), 32'd0);
        resetModel();
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, OP_ADD, 5'd10, 5'd1, 5'd12, 1'b0);
        applyStimulus(1'b1, OP_LDUR, 5'd2, 5'd0, 5'd13, 1'b0);
        applyStimulus(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd13, 1'b0);
        applyStimulus(1'b1, OP_CBZ, 5'd0, 5'd0, 5'd13, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
